// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: values shared by the cache and the memory responder.
//   MEM_WORD_SIZE  - data/address width in bits
//   MEM_BLOCK_SIZE - words per line-fill burst (power of 2)
//   MEM_OFFSET_W   - width of the word-within-line offset
//   state_t        - responder FSM states
package mem_responder_pkg;

  localparam int unsigned MEM_WORD_SIZE  = 16;
  localparam int unsigned MEM_BLOCK_SIZE = 4;
  localparam int unsigned MEM_OFFSET_W   = $clog2(MEM_BLOCK_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port word storage, synchronous write, asynchronous read.
//   clk   - write clock
//   we    - write enable, commits wdata to mem[addr] on the rising edge
//   addr  - word index (shared by read and write)
//   wdata - write data
//   rdata - combinational read of mem[addr]
// Contents are not cleared by reset.
module mem_array #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_SIZE-1:0]  wdata,
  output logic [WORD_SIZE-1:0]  rdata
);

  logic [WORD_SIZE-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the cache memory port.
// Serves single-word writes and BLOCK_SIZE-word line-fill reads after a
// programmable LATENCY.
//   clk           - sole clock, rising edge
//   reset         - synchronous, active-high
//   mem_read_req  - level request for a line fill
//   mem_write_req - level request for a single-word write (wins over read)
//   mem_addr      - word address, latched on acceptance
//   mem_data      - bidirectional data; driven here only during read beats
//   mem_ready     - read beat valid / write commit acknowledge
//   mem_beat      - index of the current read beat
//   mem_busy      - high whenever the FSM is not IDLE
//   num_reads     - completed line fills (wraps)
//   num_writes    - committed writes (wraps)
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = MEM_WORD_SIZE,
  parameter int unsigned BLOCK_SIZE = MEM_BLOCK_SIZE,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_read_req,
  input  logic                          mem_write_req,
  input  logic [WORD_SIZE-1:0]          mem_addr,
  inout  wire  [WORD_SIZE-1:0]          mem_data,
  output logic                          mem_ready,
  output logic [$clog2(BLOCK_SIZE)-1:0] mem_beat,
  output logic                          mem_busy,
  output logic [WORD_SIZE-1:0]          num_reads,
  output logic [WORD_SIZE-1:0]          num_writes
);

  localparam int unsigned OFF_W = $clog2(BLOCK_SIZE);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DEPTH_LOG2-1:0] base;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [WORD_SIZE-1:0]  wr_data;

  logic                  arr_we;
  logic [DEPTH_LOG2-1:0] arr_addr;
  logic [WORD_SIZE-1:0]  arr_rdata;

  // Address bits above the storage depth alias onto the same words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[WORD_SIZE-1:DEPTH_LOG2];

  // Commit happens on the edge that leaves WR_WAIT with the counter at zero.
  assign arr_we   = (state == WR_WAIT) && (cnt == '0);
  // base is line-aligned, so OR-ing the beat in never carries into the tag.
  assign arr_addr = (state == WR_WAIT) ? wr_addr : (base | DEPTH_LOG2'(mem_beat));

  mem_array #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(wr_data),
    .rdata(arr_rdata)
  );

  assign mem_data = (state == RD_BURST) ? arr_rdata : 'z;
  assign mem_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      base       <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      mem_ready  <= 1'b0;
      mem_beat   <= '0;
      num_reads  <= '0;
      num_writes <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_write_req) begin
            wr_addr <= mem_addr[DEPTH_LOG2-1:0];
            wr_data <= mem_data;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= WR_WAIT;
          end else if (mem_read_req) begin
            base  <= {mem_addr[DEPTH_LOG2-1:OFF_W], {OFF_W{1'b0}}};
            cnt   <= CNT_W'(LATENCY - 1);
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            mem_ready <= 1'b1;
            mem_beat  <= '0;
            state     <= RD_BURST;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RD_BURST: begin
          if (mem_beat == OFF_W'(BLOCK_SIZE - 1)) begin
            mem_ready <= 1'b0;
            mem_beat  <= '0;
            num_reads <= num_reads + WORD_SIZE'(1);
            state     <= DONE;
          end else begin
            mem_beat <= mem_beat + OFF_W'(1);
          end
        end
        WR_WAIT: begin
          if (cnt == '0) begin
            mem_ready  <= 1'b1;
            num_writes <= num_writes + WORD_SIZE'(1);
            state      <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          mem_ready <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks on a LATENCY=4 responder plus randomized
// protocol traffic on two 8-bit responders with LATENCY=1 and LATENCY=7.
// The bench drives the data bus whenever the responder must not, so any
// stray drive from the responder corrupts the value the bench expects.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic clk;
  logic reset;
  logic rd, wr;
  logic [15:0] addr;
  logic [15:0] tb_bus;
  logic tb_writing;
  wire  [15:0] bus;
  logic ready, busy;
  logic [MEM_OFFSET_W-1:0] beat;
  logic [15:0] nrd, nwr;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [15:0] rbeats [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus = (ready && !tb_writing) ? 'z : tb_bus;

  mem_responder #(
    .WORD_SIZE (16),
    .BLOCK_SIZE(4),
    .DEPTH_LOG2(10),
    .LATENCY   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read_req (rd),
    .mem_write_req(wr),
    .mem_addr     (addr),
    .mem_data     (bus),
    .mem_ready    (ready),
    .mem_beat     (beat),
    .mem_busy     (busy),
    .num_reads    (nrd),
    .num_writes   (nwr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock edge, then sample/drive at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                          input logic with_read, input string tag);
    bit seen;
    seen = 1'b0;
    addr = a; tb_bus = d; tb_writing = 1'b1; wr = 1'b1; rd = with_read;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (ready) begin
        seen = 1'b1;
        check({tag, " ack bus"}, bus, d);
        wr = 1'b0; rd = 1'b0;
      end
    end
    wr = 1'b0; rd = 1'b0;
    check({tag, " ack seen"}, seen, 1);
    step();
    tb_writing = 1'b0; tb_bus = '0;
  endtask

  task automatic do_read(input logic [15:0] a, input string tag);
    int unsigned got;
    bit fin;
    got = 0; fin = 1'b0;
    addr = a; rd = 1'b1;
    for (int k = 0; k < 60 && !fin; k++) begin
      step();
      if (ready) begin
        check({tag, " beat idx"}, beat, got);
        if (got < 4) rbeats[got] = bus;
        got++;
      end else if (got != 0) begin
        fin = 1'b1;
        rd  = 1'b0;
      end
    end
    rd = 1'b0;
    check({tag, " beat count"}, got, 4);
    step();
  endtask

  // Randomized traffic on narrow responders: counters wrap after 256 events.
  for (genvar g = 0; g < 2; g++) begin : g_stress
    localparam int unsigned LAT = (g == 0) ? 1 : 7;
    logic s_reset, s_rd, s_wr, s_ready, s_busy, s_writing;
    logic [7:0] s_addr, s_bus, s_nrd, s_nwr;
    logic [MEM_OFFSET_W-1:0] s_beat;
    wire  [7:0] s_data;
    logic [7:0] model [16];
    bit   valid [16];
    bit   s_done = 1'b0;

    assign s_data = (s_ready && !s_writing) ? 'z : s_bus;

    mem_responder #(
      .WORD_SIZE (8),
      .BLOCK_SIZE(4),
      .DEPTH_LOG2(4),
      .LATENCY   (LAT)
    ) u_dut (
      .clk          (clk),
      .reset        (s_reset),
      .mem_read_req (s_rd),
      .mem_write_req(s_wr),
      .mem_addr     (s_addr),
      .mem_data     (s_data),
      .mem_ready    (s_ready),
      .mem_beat     (s_beat),
      .mem_busy     (s_busy),
      .num_reads    (s_nrd),
      .num_writes   (s_nwr)
    );

    initial begin
      int unsigned kind, got, first, n_rd, n_wr;
      logic [7:0] a, d;
      logic [3:0] idx;
      bit fin, is_wr;
      for (int i = 0; i < 16; i++) valid[i] = 1'b0;
      s_reset = 1'b1; s_rd = 1'b0; s_wr = 1'b0; s_writing = 1'b0;
      s_bus = '0; s_addr = '0; n_rd = 0; n_wr = 0;
      @(negedge clk);
      step(); step();
      s_reset = 1'b0;
      for (int r = 0; r < 1000; r++) begin
        kind  = $urandom_range(0, 2);   // 0 read, 1 write, 2 both
        a     = 8'($urandom);
        d     = 8'($urandom);
        is_wr = (kind != 0);
        got = 0; first = 0; fin = 1'b0;
        s_addr = a; s_rd = (kind != 1); s_wr = is_wr;
        s_writing = is_wr; s_bus = is_wr ? d : 8'h00;
        for (int k = 0; k < 40 && !fin; k++) begin
          step();
          if (s_ready) begin
            if (got == 0) first = k;
            if (is_wr) begin
              check($sformatf("L%0d wr ack bus", LAT), s_data, d);
              model[a[3:0]] = d; valid[a[3:0]] = 1'b1;
              n_wr++; got = 1; fin = 1'b1;
              s_wr = 1'b0; s_rd = 1'b0;
            end else begin
              check($sformatf("L%0d rd beat idx", LAT), s_beat, got);
              idx = {a[3:2], 2'(got)};
              if (valid[idx]) check($sformatf("L%0d rd data", LAT), s_data, model[idx]);
              got++;
            end
          end else begin
            check($sformatf("L%0d bus undriven", LAT), s_data, s_bus);
            if (!is_wr && got != 0) begin
              fin = 1'b1; s_rd = 1'b0; n_rd++;
              check($sformatf("L%0d rd beat count", LAT), got, 4);
            end
          end
        end
        s_rd = 1'b0; s_wr = 1'b0;
        check($sformatf("L%0d txn done", LAT), fin, 1);
        check($sformatf("L%0d first ready", LAT), first, LAT);
        step();
        s_writing = 1'b0; s_bus = '0;
      end
      check($sformatf("L%0d num_reads wrap", LAT), s_nrd, n_rd % 256);
      check($sformatf("L%0d num_writes wrap", LAT), s_nwr, n_wr % 256);
      s_done = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int unsigned rdy_cnt;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0;
    tb_bus = '0; tb_writing = 1'b0;
    @(negedge clk);
    step(); step();
    reset = 1'b0;
    step();
    check("rst ready", ready, 0);
    check("rst beat", beat, 0);
    check("rst busy", busy, 0);
    check("rst num_reads", nrd, 0);
    check("rst num_writes", nwr, 0);
    check("rst bus", bus, 16'h0000);

    for (int i = 0; i < 4; i++)
      do_write(16'h0010 + 16'(i), 16'h00A0 + 16'(i), 1'b0, "preload");
    check("preload num_writes", nwr, 4);

    // Write 0x5A5A to 0x0021, accepted at edge 0, commit at edge 4.
    addr = 16'h0021; tb_bus = 16'h5A5A; tb_writing = 1'b1; wr = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      check($sformatf("wr ready e%0d", k), ready, (k == 4));
      check($sformatf("wr busy e%0d", k), busy, (k <= 4));
      if (k == 4) begin
        wr = 1'b0;
        check("wr ack bus", bus, 16'h5A5A);
        check("wr num_writes", nwr, 5);
      end
      if (k == 5) begin
        tb_writing = 1'b0; tb_bus = '0;
      end
    end

    // Line fill at 0x0012; mid-burst the read drops and a write with a new
    // address appears, neither of which may disturb the burst.
    addr = 16'h0012; rd = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      step();
      check($sformatf("rd ready e%0d", k), ready, (k >= 4 && k <= 7));
      check($sformatf("rd busy e%0d", k), busy, (k <= 8));
      if (k >= 4 && k <= 7) begin
        check($sformatf("rd beat e%0d", k), beat, k - 4);
        check($sformatf("rd data e%0d", k), bus, 16'h00A0 + 16'(k - 4));
      end else begin
        check($sformatf("rd bus idle e%0d", k), bus, 16'h0000);
      end
      if (k == 5) begin
        rd = 1'b0; wr = 1'b1; addr = 16'h0030;
      end
      if (k == 8) wr = 1'b0;
    end
    check("fill num_reads", nrd, 1);
    check("fill num_writes", nwr, 5);

    do_read(16'h0020, "rd 0x20");
    check("rd 0x20 beat1", rbeats[1], 16'h5A5A);
    check("rd 0x20 num_reads", nrd, 2);

    do_read(16'h0410, "alias");
    for (int i = 0; i < 4; i++)
      check($sformatf("alias beat%0d", i), rbeats[i], 16'h00A0 + 16'(i));

    do_write(16'h0040, 16'h1357, 1'b1, "simul");
    check("simul num_reads", nrd, 3);
    check("simul num_writes", nwr, 6);
    do_read(16'h0040, "rd 0x40");
    check("rd 0x40 beat0", rbeats[0], 16'h1357);

    // Reset while waiting on a read.
    addr = 16'h0010; rd = 1'b1;
    step(); step();
    check("rdwait busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0; rd = 1'b0;
    check("rdwait rst busy", busy, 0);
    check("rdwait rst ready", ready, 0);
    check("rdwait rst bus", bus, 16'h0000);
    check("rdwait rst num_reads", nrd, 0);
    rdy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (ready) rdy_cnt++;
    end
    check("rdwait no beats", rdy_cnt, 0);

    // Reset while a write is pending: memory keeps its old word.
    addr = 16'h0011; tb_bus = 16'hDEAD; tb_writing = 1'b1; wr = 1'b1;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0; wr = 1'b0; tb_writing = 1'b0; tb_bus = '0;
    check("wrabort num_writes", nwr, 0);
    step();
    do_read(16'h0010, "wrabort rd");
    check("wrabort beat1", rbeats[1], 16'h00A1);
    check("wrabort num_reads", nrd, 1);

    wait (g_stress[0].s_done && g_stress[1].s_done);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
